cache_refill_ctrl: RTL and testbench

Direct-mapped data-cache controller placed between the RISC-V core's load/store port and main data memory. It owns the tag/valid/data storage for 16 lines of four 32-bit words. It serves read hits in one cycle and refills a whole line in four memory beats on a read miss. Writes go through to memory (write-through, no write-allocate), and the cached copy is updated when the write hits. It also keeps saturating hit/miss counters for the performance readout.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_line_store.sv | 57 +++++
 rtl/cache_refill_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, FSM state encoding and line layout for the direct-mapped
// refill cache controller.
package cache_pkg;

    localparam int ADDR_WIDTH     = 16;
    localparam int DATA_WIDTH     = 32;
    localparam int INDEX_WIDTH    = 4;
    localparam int CNT_WIDTH      = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_WIDTH   = 2;
    localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - 4;
    localparam int NUM_LINES      = 1 << INDEX_WIDTH;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESPOND,
        WRITE
    } state_t;

    typedef struct packed {
        logic                                      valid;
        logic [TAG_WIDTH-1:0]                      tag;
        logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] word;
    } line_t;

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for the direct-mapped cache: asynchronous read of one
// word, per-word data writes and per-line tag/valid writes.
module cache_line_store
    import cache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INDEX_WIDTH-1:0]  rd_index,
    input  logic [OFFSET_WIDTH-1:0] rd_offset,
    output logic                    rd_valid,
    output logic [TAG_WIDTH-1:0]    rd_tag,
    output logic [DATA_WIDTH-1:0]   rd_word,
    input  logic                    word_we,
    input  logic [INDEX_WIDTH-1:0]  word_index,
    input  logic [OFFSET_WIDTH-1:0] word_offset,
    input  logic [DATA_WIDTH-1:0]   word_data,
    input  logic                    meta_we,
    input  logic [INDEX_WIDTH-1:0]  meta_index,
    input  logic                    meta_valid,
    input  logic [TAG_WIDTH-1:0]    meta_tag
);

    logic [NUM_LINES-1:0]                      valid_q;
    logic [TAG_WIDTH-1:0]                      tag_mem  [NUM_LINES];
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] data_mem [NUM_LINES];
    line_t                                     rd_line;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (meta_we) begin
            valid_q[meta_index] <= meta_valid;
        end
    end

    // NOTE: tag/data arrays carry no reset; a cleared valid bit already makes their contents unreachable.
    always_ff @(posedge clk) begin
        if (meta_we) begin
            tag_mem[meta_index] <= meta_tag;
        end
        if (word_we) begin
            data_mem[word_index][word_offset] <= word_data;
        end
    end

    always_comb begin
        rd_line.valid = valid_q[rd_index];
        rd_line.tag   = tag_mem[rd_index];
        rd_line.word  = data_mem[rd_index];
    end

    assign rd_valid = rd_line.valid;
    assign rd_tag   = rd_line.tag;
    assign rd_word  = rd_line.word[rd_offset];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Direct-mapped write-through data cache controller: one-cycle read hits,
// four-beat line refill on read miss, saturating hit/miss counters.
module cache_refill_ctrl
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:2]   addr_q;
    logic [ADDR_WIDTH-1:2]   lk_addr;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [OFFSET_WIDTH-1:0] beat_q;
    logic                    done_q;
    logic [CNT_WIDTH-1:0]    hit_cnt;
    logic [CNT_WIDTH-1:0]    miss_cnt;

    logic                    st_valid;
    logic [TAG_WIDTH-1:0]    st_tag;
    logic [DATA_WIDTH-1:0]   st_word;

    logic                    lk_hit;
    logic                    accept;
    logic                    rd_hit;
    logic                    rd_miss;
    logic                    wr_start;
    logic                    last_beat;

    logic                    word_we;
    logic [INDEX_WIDTH-1:0]  word_index;
    logic [OFFSET_WIDTH-1:0] word_offset;
    logic [DATA_WIDTH-1:0]   word_data;
    logic                    meta_we;
    logic [INDEX_WIDTH-1:0]  meta_index;
    logic                    meta_valid;
    logic [TAG_WIDTH-1:0]    meta_tag;

    logic [1:0]              unused_byte_offset;

    assign unused_byte_offset = cpu_addr[1:0];

    // The single lookup port follows the live request in IDLE and the latched address elsewhere.
    assign lk_addr   = (state_q == IDLE) ? cpu_addr[ADDR_WIDTH-1:2] : addr_q;
    assign lk_hit    = st_valid && (st_tag == lk_addr[ADDR_WIDTH-1 -: TAG_WIDTH]);
    assign accept    = (state_q == IDLE) && cpu_req && !done_q;
    assign rd_hit    = accept && !cpu_we && lk_hit;
    assign rd_miss   = accept && !cpu_we && !lk_hit;
    assign wr_start  = accept && cpu_we;
    assign last_beat = (state_q == REFILL) && mem_ack && (&beat_q);

    cache_line_store u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_index    (lk_addr[4 +: INDEX_WIDTH]),
        .rd_offset   (lk_addr[3:2]),
        .rd_valid    (st_valid),
        .rd_tag      (st_tag),
        .rd_word     (st_word),
        .word_we     (word_we),
        .word_index  (word_index),
        .word_offset (word_offset),
        .word_data   (word_data),
        .meta_we     (meta_we),
        .meta_index  (meta_index),
        .meta_valid  (meta_valid),
        .meta_tag    (meta_tag)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cpu_stall   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        word_we     = 1'b0;
        word_index  = addr_q[4 +: INDEX_WIDTH];
        word_offset = beat_q;
        word_data   = mem_rdata;
        meta_we     = 1'b0;
        meta_index  = addr_q[4 +: INDEX_WIDTH];
        meta_valid  = 1'b0;
        meta_tag    = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];

        unique case (state_q)
            IDLE: begin
                cpu_stall = rst_n && accept && (cpu_we || !lk_hit);
                if (rd_miss) begin
                    // Invalidate at miss entry so an interrupted refill never leaves a usable line.
                    meta_we    = 1'b1;
                    meta_index = cpu_addr[4 +: INDEX_WIDTH];
                    meta_tag   = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                    state_d    = REFILL;
                end else if (wr_start) begin
                    state_d = WRITE;
                end
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {addr_q[ADDR_WIDTH-1:4], beat_q, 2'b00};
                if (mem_ack) begin
                    word_we = 1'b1;
                    if (&beat_q) begin
                        meta_we    = 1'b1;
                        meta_valid = 1'b1;
                        state_d    = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            WRITE: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q, 2'b00};
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    if (lk_hit) begin
                        word_we     = 1'b1;
                        word_offset = addr_q[3:2];
                        word_data   = wdata_q;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            beat_q   <= '0;
            done_q   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;

            if (rd_miss || wr_start) begin
                addr_q <= cpu_addr[ADDR_WIDTH-1:2];
            end
            if (wr_start) begin
                wdata_q <= cpu_wdata;
            end

            if (rd_miss) begin
                beat_q <= '0;
            end else if ((state_q == REFILL) && mem_ack) begin
                beat_q <= beat_q + OFFSET_WIDTH'(1);
            end

            if (rd_hit) begin
                rdata_q <= st_word;
                done_q  <= 1'b1;
            end
            // The requested word may be the one arriving on the final beat, not yet in the store.
            if (last_beat) begin
                rdata_q <= (lk_addr[3:2] == beat_q) ? mem_rdata : st_word;
                done_q  <= 1'b1;
            end
            if ((state_q == WRITE) && mem_ack) begin
                done_q <= 1'b1;
            end

            if (rd_hit && (hit_cnt != CNT_MAX)) begin
                hit_cnt <= hit_cnt + CNT_ONE;
            end
            if (rd_miss && (miss_cnt != CNT_MAX)) begin
                miss_cnt <= miss_cnt + CNT_ONE;
            end
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_done   = done_q;
    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a memory responder with programmable
// wait states, a reference tag/memory model, and monitors for beats and completions.
module tb_cache_refill_ctrl;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } done_t;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int err_cnt = 0;
    int chk_cnt = 0;
    int ack_wait = 0;
    int wcnt = 0;
    int beats_seen = 0;

    logic [31:0] mem_model [0:16383];
    logic [31:0] ref_mem   [0:16383];
    logic        ref_valid [0:15];
    logic [7:0]  ref_tag   [0:15];
    logic [15:0] ref_hits;
    logic [15:0] ref_misses;

    beat_t exp_beats[$];
    done_t exp_done[$];
    beat_t mon_beat;
    done_t mon_done;

    cache_refill_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .cpu_done   (cpu_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        chk_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Memory responder: drives ack just after the rising edge, after ack_wait idle cycles per beat.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (rst_n && mem_req) begin
                if (wcnt >= ack_wait) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                    if (!mem_we) mem_rdata = mem_model[mem_addr[15:2]];
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Beat monitor: each ack seen with a request is one consumed beat.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_req && mem_ack) begin
                beats_seen++;
                check("beat_expected", 32'(exp_beats.size() != 0), 32'd1);
                if (exp_beats.size() != 0) begin
                    mon_beat = exp_beats.pop_front();
                    check("beat_we", 32'(mem_we), 32'(mon_beat.we));
                    check("beat_addr", 32'(mem_addr), 32'(mon_beat.addr));
                    if (mon_beat.we) check("beat_wdata", mem_wdata, mon_beat.data);
                end
                if (mem_we) mem_model[mem_addr[15:2]] = mem_wdata;
            end
        end
    end

    // Completion monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cpu_done) begin
                check("done_expected", 32'(exp_done.size() != 0), 32'd1);
                if (exp_done.size() != 0) begin
                    mon_done = exp_done.pop_front();
                    if (mon_done.is_read) check("rdata", cpu_rdata, mon_done.data);
                end
            end
        end
    end

    task automatic predict_read(input logic [15:0] addr, output logic hit);
        int idx;
        idx = int'(addr[7:4]);
        hit = ref_valid[idx] && (ref_tag[idx] == addr[15:8]);
        if (hit) begin
            if (ref_hits != 16'hFFFF) ref_hits++;
        end else begin
            for (int b = 0; b < 4; b++) begin
                logic [1:0] bb;
                bb = 2'(b);
                exp_beats.push_back('{1'b0, {addr[15:4], bb, 2'b00}, 32'h0});
            end
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = addr[15:8];
            if (ref_misses != 16'hFFFF) ref_misses++;
        end
        exp_done.push_back('{1'b1, ref_mem[addr[15:2]]});
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [31:0] wd, input int exp_lat);
        logic hit;
        logic done;
        int   cycles;
        @(negedge clk);
        check("done_pulse", 32'(cpu_done), 32'd0);
        hit = 1'b0;
        if (we) begin
            ref_mem[addr[15:2]] = wd;
            exp_beats.push_back('{1'b1, {addr[15:2], 2'b00}, wd});
            exp_done.push_back('{1'b0, 32'h0});
        end else begin
            predict_read(addr, hit);
        end
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        #1;
        check("stall", 32'(cpu_stall), 32'(we || !hit));
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (cpu_done) done = 1'b1;
        end
        check("done_seen", 32'(done), 32'd1);
        check("latency", cycles, exp_lat);
        cpu_req = 1'b0;
        check("hit_count", 32'(hit_count), 32'(ref_hits));
        check("miss_count", 32'(miss_count), 32'(ref_misses));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rdata"}, cpu_rdata, 32'h0);
        check({tag, "_stall"}, 32'(cpu_stall), 32'h0);
        check({tag, "_done"}, 32'(cpu_done), 32'h0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_hits"}, 32'(hit_count), 32'h0);
        check({tag, "_misses"}, 32'(miss_count), 32'h0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 8'h0;
        end
        ref_hits   = '0;
        ref_misses = '0;
    endtask

    initial begin
        #900_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int cycles;
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 16384; i++) begin
            mem_model[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem_model[16'h0040 >> 2] = 32'h11;
        mem_model[16'h0044 >> 2] = 32'h22;
        mem_model[16'h0048 >> 2] = 32'h33;
        mem_model[16'h004C >> 2] = 32'h44;
        for (int i = 0; i < 16384; i++) begin
            ref_mem[i] = mem_model[i];
        end
        clear_model();

        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Cold read with two wait states per beat, then hits in the same line.
        ack_wait = 2;
        cpu_access(1'b0, 16'h0048, 32'h0, 13);
        ack_wait = 0;
        cpu_access(1'b0, 16'h004C, 32'h0, 1);
        cpu_access(1'b0, 16'h0044, 32'h0, 1);

        // Conflict on index 4, store hit, then eviction back to tag 0.
        cpu_access(1'b0, 16'h1240, 32'h0, 5);
        cpu_access(1'b1, 16'h1244, 32'hDEAD_BEEF, 2);
        cpu_access(1'b0, 16'h1244, 32'h0, 1);
        cpu_access(1'b0, 16'h0040, 32'h0, 5);

        // Store miss leaves the line invalid.
        cpu_access(1'b1, 16'h8000, 32'h0BAD_F00D, 2);
        cpu_access(1'b0, 16'h8000, 32'h0, 5);

        // Store hit with wait states, then read back from the cache.
        ack_wait = 3;
        cpu_access(1'b1, 16'h0044, 32'h1234_5678, 5);
        ack_wait = 0;
        cpu_access(1'b0, 16'h0044, 32'h0, 1);

        // Reset in the middle of a refill.
        @(negedge clk);
        ack_wait = 2;
        base = beats_seen;
        predict_read(16'h2050, base[0]);
        base      = beats_seen;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h2050;
        cpu_req   = 1'b1;
        cycles    = 0;
        while ((beats_seen - base) < 2 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("rst_two_beats", beats_seen - base, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrefill_reset");
        cpu_req = 1'b0;
        exp_beats.delete();
        exp_done.delete();
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cpu_access(1'b0, 16'h2050, 32'h0, 13);

        // Hit counter saturation.
        ack_wait = 0;
        @(negedge clk);
        force dut.hit_cnt = 16'hFFFD;
        @(negedge clk);
        release dut.hit_cnt;
        ref_hits = 16'hFFFD;
        repeat (3) cpu_access(1'b0, 16'h2050, 32'h0, 1);

        repeat (2) @(negedge clk);
        check("beats_left", 32'(exp_beats.size()), 32'd0);
        check("dones_left", 32'(exp_done.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
